des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 134 +++++++++++++
 tb/tb_des_key_schedule.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
`timescale 1ns/1ps
// DES key schedule: walks the C/D halves through the 16 rounds and emits
// PC-2(C,D) for each round, forward (K1..K16) or reverse (K16..K1).
//
// Handshake: a subkey transfers on every rising edge where subkey_valid and
// subkey_ready are both high. The producer holds subkey/round stable while
// valid is high and ready is low. Ready without valid is ignored.
//
// Bit numbering follows FIPS 46-3: bit 1 is the most significant bit of
// key_pc1 and subkey. C and D are held in ascending [1:28] vectors so that
// the index matches the FIPS bit number directly.
module des_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [56:1]  key_pc1,
    input  logic         subkey_ready,
    output logic [48:1]  subkey,
    output logic         subkey_valid,
    output logic [4:0]   round,
    output logic         busy,
    output logic         done
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // PC-2 selection: subkey bit j takes CD bit PC2[j].
    localparam int PC2 [1:48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    state_t       r_state;
    logic [1:28]  r_c;
    logic [1:28]  r_d;
    logic [4:0]   r_round;
    logic         r_dir;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic [1:56]  w_cd;
    logic [1:48]  w_pc2;
    logic         w_accept;
    logic         w_last;

    // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
    function automatic logic shift_one(input logic [4:0] rnd);
        return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
    endfunction

    // Left rotate in FIPS numbering: new bit i = old bit i+1, wrapping bit 1.
    function automatic logic [1:28] rot_left(input logic [1:28] v, input logic one);
        return one ? {v[2:28], v[1]} : {v[3:28], v[1:2]};
    endfunction

    // Right rotate: exact inverse of rot_left for the same amount.
    function automatic logic [1:28] rot_right(input logic [1:28] v, input logic one);
        return one ? {v[28], v[1:27]} : {v[27:28], v[1:26]};
    endfunction

    assign w_accept = r_valid & subkey_ready;
    assign w_last   = r_dir ? (r_round == 5'd1) : (r_round == 5'd16);
    assign w_cd     = {r_c, r_d};

    // PC-2 permutation of the current C/D registers.
    always_comb begin
        w_pc2 = '0;
        for (int j = 1; j <= 48; j++) begin
            w_pc2[j] = w_cd[PC2[j]];
        end
    end

    // Control FSM plus C/D rotation; busy mirrors the state for observation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_round <= '0;
            r_dir   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // C16D16 equals C0D0, so reverse order loads unrotated.
                        r_c     <= decrypt ? key_pc1[56:29] : rot_left(key_pc1[56:29], 1'b1);
                        r_d     <= decrypt ? key_pc1[28:1]  : rot_left(key_pc1[28:1], 1'b1);
                        r_round <= decrypt ? 5'd16 : 5'd1;
                        r_dir   <= decrypt;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_round <= '0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_dir) begin
                            // Undo the shift that produced the current round.
                            r_c     <= rot_right(r_c, shift_one(r_round));
                            r_d     <= rot_right(r_d, shift_one(r_round));
                            r_round <= r_round - 5'd1;
                        end else begin
                            r_c     <= rot_left(r_c, shift_one(r_round + 5'd1));
                            r_d     <= rot_left(r_d, shift_one(r_round + 5'd1));
                            r_round <= r_round + 5'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign subkey       = r_valid ? w_pc2 : '0;
    assign subkey_valid = r_valid;
    assign round        = r_round;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
`timescale 1ns/1ps
// Bench for des_key_schedule: directed vectors plus a DES key-schedule model.
module tb_des_key_schedule;

  localparam logic [55:0] KEY_A = 56'hF0CCAAF556678F;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        decrypt;
  logic [56:1] key_pc1;
  logic        subkey_ready;
  logic [48:1] subkey;
  logic        subkey_valid;
  logic [4:0]  round;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] exp_q[$];
  logic [47:0] acc_q[$];

  int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
  };

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .decrypt      (decrypt),
    .key_pc1      (key_pc1),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Software key schedule: 28-bit halves with FIPS bit 1 at the MSB.
  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    logic [27:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[26:0], r[27]};
    return r;
  endfunction

  function automatic logic [47:0] model_subkey(input logic [55:0] key, input int rnd);
    logic [27:0] c;
    logic [27:0] d;
    logic [55:0] cd;
    logic [47:0] ks;
    int          n;
    c = key[55:28];
    d = key[27:0];
    for (int i = 1; i <= rnd; i++) begin
      n = (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
      c = rotl28(c, n);
      d = rotl28(d, n);
    end
    cd = {c, d};
    ks = '0;
    for (int j = 0; j < 48; j++) ks[47 - j] = cd[56 - pc2_tab[j]];
    return ks;
  endfunction

  task automatic load_expected(input logic [55:0] key, input logic dec);
    exp_q.delete();
    for (int r = 1; r <= 16; r++) begin
      if (dec) exp_q.push_back(model_subkey(key, 17 - r));
      else     exp_q.push_back(model_subkey(key, r));
    end
  endtask

  // Runs one schedule starting at the current falling edge; returns at the
  // falling edge where done is high (start is left low).
  task automatic run_sched(input logic [55:0] key, input logic dec, input int ready_pct,
                           input bit noise);
    logic [47:0] held_key;
    logic [4:0]  held_round;
    logic [4:0]  exp_round;
    bit          stalled;
    bit          rdy;
    bit          got_done;
    logic [63:0] rnd64;

    load_expected(key, dec);
    acc_q.delete();
    start        = 1'b1;
    decrypt      = dec;
    key_pc1      = key;
    subkey_ready = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    decrypt = ~dec;
    check("first_valid", 64'(subkey_valid), 64'(1'b1));
    check("first_round", 64'(round), dec ? 64'd16 : 64'd1);
    check("first_busy", 64'(busy), 64'(1'b1));

    exp_round = dec ? 5'd16 : 5'd1;
    stalled   = 1'b0;
    got_done  = 1'b0;
    held_key  = '0;
    held_round = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (!subkey_valid) check("valid_drop", 64'(subkey_valid), 64'(1'b1));
      if (stalled) begin
        check("stall_subkey", 64'(subkey), 64'(held_key));
        check("stall_round", 64'(round), 64'(held_round));
      end
      rdy = ($urandom_range(99) < ready_pct);
      subkey_ready = rdy;
      if (subkey_valid && rdy) begin
        acc_q.push_back(subkey);
        if (exp_q.size() == 0) begin
          check("extra_subkey", 64'(subkey), 64'd0);
        end else begin
          check("subkey", 64'(subkey), 64'(exp_q.pop_front()));
        end
        check("round", 64'(round), 64'(exp_round));
        exp_round = dec ? exp_round - 5'd1 : exp_round + 5'd1;
      end
      stalled    = subkey_valid && !rdy;
      held_key   = subkey;
      held_round = round;
      if (noise) begin
        start   = 1'($urandom_range(1));
        decrypt = 1'($urandom_range(1));
        rnd64   = {$urandom(), $urandom()};
        key_pc1 = rnd64[55:0];
      end
      @(negedge clk);
    end
    start        = 1'b0;
    subkey_ready = 1'b0;
    check("done_seen", 64'(got_done), 64'(1'b1));
    check("done_valid_low", 64'(subkey_valid), 64'(1'b0));
    check("done_subkey_zero", 64'(subkey), 64'd0);
    check("done_round_zero", 64'(round), 64'd0);
    check("done_busy_low", 64'(busy), 64'(1'b0));
    check("accepted_count", 64'(acc_q.size()), 64'd16);
  endtask

  // One idle cycle after done: done must already have dropped.
  task automatic idle_gap();
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(1'b0));
    check("idle_valid", 64'(subkey_valid), 64'(1'b0));
    check("idle_busy", 64'(busy), 64'(1'b0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_subkey"}, 64'(subkey), 64'd0);
    check({tag, "_valid"}, 64'(subkey_valid), 64'd0);
    check({tag, "_round"}, 64'(round), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [63:0] rnd64;
    logic [55:0] rkey;
    logic        rdec;
    int          guard;
    bit          saw_done;

    // reset
    rst_n        = 1'b0;
    start        = 1'b0;
    decrypt      = 1'b0;
    key_pc1      = '0;
    subkey_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ready while idle does nothing
    subkey_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle_ready");
    subkey_ready = 1'b0;

    // encrypt directed vector
    run_sched(KEY_A, 1'b0, 100, 1'b0);
    check("enc_k1", 64'(acc_q[0]), 64'(K1_A));
    check("enc_k16", 64'(acc_q[15]), 64'(K16_A));
    idle_gap();

    // decrypt directed vector
    run_sched(KEY_A, 1'b1, 100, 1'b0);
    check("dec_first", 64'(acc_q[0]), 64'(K16_A));
    check("dec_last", 64'(acc_q[15]), 64'(K1_A));
    idle_gap();

    // backpressure at roughly 30% ready
    run_sched(KEY_A, 1'b0, 30, 1'b0);
    check("bp_k1", 64'(acc_q[0]), 64'(K1_A));
    idle_gap();

    // reset at round 7, with start and a handshake in the same cycle
    start        = 1'b1;
    decrypt      = 1'b0;
    key_pc1      = KEY_A;
    subkey_ready = 1'b0;
    @(negedge clk);
    start        = 1'b0;
    subkey_ready = 1'b1;
    guard        = 0;
    while (round != 5'd7 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reach_round7", 64'(round), 64'd7);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n        = 1'b1;
    start        = 1'b0;
    subkey_ready = 1'b0;
    saw_done     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", 64'(saw_done), 64'd0);
    check_all_zero("post_reset");
    run_sched(56'h0123456789ABCD, 1'b0, 100, 1'b0);
    idle_gap();

    // noise during run, then a second schedule started in the done cycle
    run_sched(56'h13579BDF02468A, 1'b0, 70, 1'b1);
    run_sched(56'hFEDCBA98765432, 1'b1, 100, 1'b1);
    idle_gap();

    // random keys, both directions
    for (int t = 0; t < 6; t++) begin
      rnd64 = {$urandom(), $urandom()};
      rkey  = rnd64[55:0];
      rdec  = 1'(t % 2);
      run_sched(rkey, rdec, $urandom_range(100, 30), 1'b0);
      idle_gap();
      run_sched(rkey, ~rdec, 100, 1'b0);
      idle_gap();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
